// File: rtl/round_share_arb.sv
// Round-robin arbiter sharing one combinational rounder among N_REQ requesters,
// with a registered valid/ready result stage and per-requester sticky inexact flags.
module round_share_arb #(
    parameter int N_REQ = 2,
    parameter int ID_W  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_REQ-1:0]      req_valid,
    output logic [N_REQ-1:0]      req_ready,
    input  logic [N_REQ*24-1:0]   req_mantissa,
    input  logic [N_REQ-1:0]      req_guard,
    input  logic [N_REQ-1:0]      req_sticky,
    input  logic [N_REQ-1:0]      req_sign,
    input  logic [N_REQ*3-1:0]    req_mode,
    output logic [23:0]           rnd_mantissa_in,
    output logic                  rnd_guard,
    output logic                  rnd_sticky,
    output logic                  rnd_sign,
    output logic [2:0]            rnd_mode,
    input  logic [24:0]           rnd_mantissa_out,
    input  logic                  rnd_sign_out,
    input  logic                  rnd_inexact,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [24:0]           res_mantissa,
    output logic                  res_sign,
    output logic                  res_inexact,
    output logic [ID_W-1:0]       res_id,
    output logic [N_REQ-1:0]      flag_inexact,
    input  logic [N_REQ-1:0]      flag_clr
);

    localparam int unsigned N = N_REQ;

    logic              res_valid_q,   res_valid_d;
    logic [24:0]       res_mant_q,    res_mant_d;
    logic              res_sign_q,    res_sign_d;
    logic              res_inexact_q, res_inexact_d;
    logic [ID_W-1:0]   res_id_q,      res_id_d;
    logic [ID_W-1:0]   last_grant_q,  last_grant_d;
    logic [N_REQ-1:0]  flag_q,        flag_d;

    logic              slot_free;
    logic              grant_any;
    logic [ID_W-1:0]   grant_idx;
    logic [ID_W-1:0]   sel_idx;
    logic [N_REQ-1:0]  grant_oh;
    int unsigned       cand;

    // Candidate order starts just after last_grant; inner loop keeps every select index constant.
    always_comb begin
        slot_free = !res_valid_q || res_ready;
        grant_any = 1'b0;
        grant_idx = '0;
        grant_oh  = '0;
        cand      = 0;
        for (int unsigned k = 1; k <= N; k++) begin
            cand = (32'(last_grant_q) + k) % N;
            for (int unsigned i = 0; i < N; i++) begin
                if (!grant_any && slot_free && !rst && i == cand && req_valid[i]) begin
                    grant_any   = 1'b1;
                    grant_idx   = ID_W'(i);
                    grant_oh[i] = 1'b1;
                end
            end
        end
    end

    assign req_ready = grant_oh;
    assign sel_idx   = grant_any ? grant_idx : last_grant_q;

    always_comb begin
        rnd_mantissa_in = req_mantissa[23:0];
        rnd_guard       = req_guard[0];
        rnd_sticky      = req_sticky[0];
        rnd_sign        = req_sign[0];
        rnd_mode        = req_mode[2:0];
        for (int unsigned i = 0; i < N; i++) begin
            if (sel_idx == ID_W'(i)) begin
                rnd_mantissa_in = req_mantissa[i*24 +: 24];
                rnd_guard       = req_guard[i];
                rnd_sticky      = req_sticky[i];
                rnd_sign        = req_sign[i];
                rnd_mode        = req_mode[i*3 +: 3];
            end
        end
    end

    always_comb begin
        res_valid_d   = res_valid_q;
        res_mant_d    = res_mant_q;
        res_sign_d    = res_sign_q;
        res_inexact_d = res_inexact_q;
        res_id_d      = res_id_q;
        last_grant_d  = last_grant_q;
        if (grant_any) begin
            res_valid_d   = 1'b1;
            res_mant_d    = rnd_mantissa_out;
            res_sign_d    = rnd_sign_out;
            res_inexact_d = rnd_inexact;
            res_id_d      = grant_idx;
            last_grant_d  = grant_idx;
        end else if (res_ready) begin
            res_valid_d   = 1'b0;
        end
        // Set term applied after the clear so a same-cycle set is never lost.
        flag_d = (flag_q & ~flag_clr) | (grant_oh & {N_REQ{rnd_inexact}});
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            res_valid_q   <= 1'b0;
            res_mant_q    <= '0;
            res_sign_q    <= 1'b0;
            res_inexact_q <= 1'b0;
            res_id_q      <= '0;
            last_grant_q  <= ID_W'(N_REQ - 1);
            flag_q        <= '0;
        end else begin
            res_valid_q   <= res_valid_d;
            res_mant_q    <= res_mant_d;
            res_sign_q    <= res_sign_d;
            res_inexact_q <= res_inexact_d;
            res_id_q      <= res_id_d;
            last_grant_q  <= last_grant_d;
            flag_q        <= flag_d;
        end
    end

    assign res_valid    = res_valid_q;
    assign res_mantissa = res_mant_q;
    assign res_sign     = res_sign_q;
    assign res_inexact  = res_inexact_q;
    assign res_id       = res_id_q;
    assign flag_inexact = flag_q;

endmodule

// File: doc/round_share_arb.md
Name: round_share_arb

Overview:
- Shares one rounding unit (`round_mult`-style datapath) between N_REQ multiplier pipelines.
- Each cycle, arbitrates round-robin among valid requesters and drives the winner's pre-round mantissa, guard, sticky, sign and round mode onto the shared rounder.
- Captures the rounder result plus requester ID in a registered output stage with valid/ready backpressure.
- Keeps per-requester sticky IEEE inexact flags for status reporting.

Parameters:
- N_REQ, 2, number of requesters (legal range 2..8).
- ID_W, 1, width of requester ID; must equal max(1, $clog2(N_REQ)).

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  N_REQ  per-requester request valid
- req_ready  out  N_REQ  per-requester accept (one-hot or zero)
- req_mantissa  in  N_REQ*24  packed pre-round mantissas; requester i at [24i+23:24i]
- req_guard  in  N_REQ  guard bits
- req_sticky  in  N_REQ  sticky bits
- req_sign  in  N_REQ  sign bits
- req_mode  in  N_REQ*3  packed rounding modes (rounding_pkg encoding)
- rnd_mantissa_in  out  24  to shared rounder
- rnd_guard  out  1  to shared rounder
- rnd_sticky  out  1  to shared rounder
- rnd_sign  out  1  to shared rounder
- rnd_mode  out  3  to shared rounder
- rnd_mantissa_out  in  25  from shared rounder (combinational)
- rnd_sign_out  in  1  from shared rounder
- rnd_inexact  in  1  from shared rounder
- res_valid  out  1  output register holds a result
- res_ready  in  1  downstream accepts result
- res_mantissa  out  25  rounded mantissa incl. carry bit 24
- res_sign  out  1  result sign
- res_inexact  out  1  result inexact
- res_id  out  ID_W  index of requester that produced the result
- flag_inexact  out  N_REQ  sticky inexact flag per requester
- flag_clr  in  N_REQ  per-requester flag clear

Behaviour:
Reset (rst=1 at edge):
- res_valid=0; res_mantissa, res_sign, res_inexact, res_id = 0; flag_inexact=0.
- Round-robin pointer set so requester 0 has highest priority (last_grant=N_REQ-1).
- Reset mid-transaction discards any held result; no req_ready is asserted while rst=1.

Slot free (combinational):
- slot_free = !res_valid || res_ready.

Grant (combinational):
- If slot_free, grant the first valid requester searching from (last_grant+1) mod N_REQ upward with wrap-around. Otherwise no grant.
- req_ready = one-hot grant vector; all zero when no valid requester or !slot_free.
- req_ready must not depend combinationally on req_valid of the granted index beyond the arbitration itself.

Rounder drive:
- rnd_* outputs carry the granted requester's fields.
- With no grant, they carry requester index last_grant's fields (stable; no X).
- The rounder is combinational; its outputs are sampled in the same cycle.

Capture (edge with a grant):
- res_mantissa<=rnd_mantissa_out, res_sign<=rnd_sign_out, res_inexact<=rnd_inexact, res_id<=granted index.
- res_valid<=1; last_grant<=granted index.
- Latency: request accepted in cycle T gives res_valid in T+1.
- Throughput: 1 result/cycle when res_ready is held high.

Drain:
- Edge with res_valid & res_ready and no new grant: res_valid<=0.
- Simultaneous drain and grant: new result loaded, res_valid stays 1.

Hold:
- res_valid & !res_ready: all res_* held stable; no grant issued.

Requester protocol:
- Requester holds req_valid and data stable until req_ready.
- A dropped req_valid before ready is permitted and simply loses arbitration.

Inexact flags:
- flag_inexact[i] set on capture edge when granted index=i and rnd_inexact=1.
- flag_clr[i] clears it; set and clear in the same cycle gives set wins, so no event is lost.

Fairness:
- With all requesters continuously valid and res_ready=1, grants rotate 0,1,...,N_REQ-1,0.
- No requester waits more than N_REQ grants.

Test Plan:
1. Reset release; req0 mantissa=0x7FFFFF, guard=1, sticky=1, sign=0, mode=IEEE_near -> req_ready[0]=1 in T; T+1 res_valid=1, res_mantissa=0x0800000, res_inexact=1, res_id=0, flag_inexact[0]=1.
2. N_REQ=2, both valid every cycle, res_ready=1 -> res_id sequence 0,1,0,1; one result per cycle; each requester's rounded value correct for its own mode (req1 mode=IEEE_zero, mantissa=0x123456, guard=1 -> 0x0123456).
3. Backpressure: res_ready=0 for 3 cycles with req1 valid -> res_* stable, req_ready=0; res_ready=1 -> same-cycle drain and grant of req1, res_valid stays 1.
4. flag_clr[0] and an inexact result for req0 in the same cycle -> flag_inexact[0]=1; next cycle clear alone -> 0; exact result (guard=0, sticky=0) leaves flag 0.
5. rst asserted while res_valid=1 and req0 valid -> next edge res_valid=0, flags 0, req_ready=0 during reset; first grant after reset goes to req0.
6. N_REQ=3, only req2 valid after a req0 grant -> req2 granted; then req0 and req1 valid -> order 0,1 (pointer wraps from 2).
